scd_diag_reader: RTL and testbench

//  Diagnostic EBUS read sequencer; the requesting end of the SCD diag-read path.

---
 rtl/scd_diag_reader.sv | 178 +++++++++++++++++
 tb/tb_scd_diag_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scd_diag_reader.sv
`default_nettype none
// ============================================================================
// Module      : scd_diag_reader
// Description : Diagnostic EBUS read sequencer. Issues DIAG function 13X,
//               waits for the SCD to drive the EBUS, lets it settle, captures
//               the 36-bit word and releases the bus. Single read or a sweep
//               of all eight functions 130..137.
// Revision    : 1.0 - initial release
// ============================================================================
module scd_diag_reader #(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        REQ,
    input  logic        REQ_SWEEP,
    input  logic [0:2]  REQ_FUNC,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        RD_VALID,
    output logic [0:2]  RD_FUNC,
    output logic [0:35] RD_DATA,
    output logic [0:8]  CRAM_DIAG_FUNC,
    output logic        DIAG_READ_FUNC_13X,
    input  logic        SCDdrivingEBUS,
    input  logic [0:35] SCD_EBUS
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_ISSUE   = 3'd1;
    localparam logic [2:0] c_ST_SETTLE  = 3'd2;
    localparam logic [2:0] c_ST_RELEASE = 3'd3;
    localparam logic [2:0] c_ST_FIN     = 3'd4;

    localparam logic [7:0] c_WAIT_LAST   = 8'(TIMEOUT - 1);
    localparam logic [3:0] c_SETTLE_INIT = 4'(SETTLE);
    localparam logic [5:0] c_FUNC_13     = 6'o13;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [2:0]  r_x;
    logic        r_sweep;
    logic        r_err;
    logic [7:0]  r_wait_cnt;
    logic [3:0]  r_settle_cnt;
    logic        r_rd_valid;
    logic [2:0]  r_rd_func;
    logic [35:0] r_rd_data;

    logic w_accept;
    logic w_wait_last;
    logic w_capture;
    logic w_next_word;
    logic w_advance;
    logic w_set_err;

    // Decoded events shared by the next-state logic and the datapath
    assign w_accept    = (r_state == c_ST_IDLE) && REQ;
    assign w_wait_last = (r_wait_cnt == c_WAIT_LAST);
    assign w_capture   = (r_state == c_ST_SETTLE) && SCDdrivingEBUS && (r_settle_cnt == 4'd1);
    assign w_next_word = !r_err && r_sweep && (r_x != 3'd7);
    assign w_advance   = (r_state == c_ST_RELEASE) && !SCDdrivingEBUS && w_next_word;
    assign w_set_err   = ((r_state == c_ST_ISSUE)   && !SCDdrivingEBUS && w_wait_last) ||
                         ((r_state == c_ST_SETTLE)  && !SCDdrivingEBUS) ||
                         ((r_state == c_ST_RELEASE) &&  SCDdrivingEBUS && w_wait_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a driver seen in ISSUE wins over a same-cycle timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) w_next_state = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                if (SCDdrivingEBUS)   w_next_state = c_ST_SETTLE;
                else if (w_wait_last) w_next_state = c_ST_RELEASE;
            end
            c_ST_SETTLE: begin
                if (!SCDdrivingEBUS || w_capture) w_next_state = c_ST_RELEASE;
            end
            c_ST_RELEASE: begin
                if (!SCDdrivingEBUS)  w_next_state = w_next_word ? c_ST_ISSUE : c_ST_FIN;
                else if (w_wait_last) w_next_state = c_ST_FIN;
            end
            c_ST_FIN: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Request context, wait/settle counters and the captured word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= 3'd0;
            r_sweep      <= 1'b0;
            r_err        <= 1'b0;
            r_wait_cnt   <= 8'd0;
            r_settle_cnt <= 4'd0;
            r_rd_valid   <= 1'b0;
            r_rd_func    <= 3'd0;
            r_rd_data    <= 36'd0;
        end else begin
            r_rd_valid <= w_capture;

            if (w_accept) begin
                r_x     <= REQ_SWEEP ? 3'd0 : REQ_FUNC;
                r_sweep <= REQ_SWEEP;
                r_err   <= 1'b0;
            end else begin
                if (w_set_err) r_err <= 1'b1;
                if (w_advance) r_x   <= r_x + 3'd1;
            end

            // Wait count restarts on every state change so ISSUE and RELEASE each get a full budget
            if (r_state != w_next_state) begin
                r_wait_cnt <= 8'd0;
            end else if ((r_state == c_ST_ISSUE) || (r_state == c_ST_RELEASE)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end

            if ((r_state == c_ST_ISSUE) && SCDdrivingEBUS) begin
                r_settle_cnt <= c_SETTLE_INIT;
            end else if ((r_state == c_ST_SETTLE) && SCDdrivingEBUS) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end

            if (w_capture) begin
                r_rd_data <= SCD_EBUS;
                r_rd_func <= r_x;
            end
        end
    end

    // Moore outputs; the function code is withdrawn in RELEASE so the SCD can let go of the bus
    always_comb begin
        CRAM_DIAG_FUNC     = 9'd0;
        DIAG_READ_FUNC_13X = 1'b0;
        BUSY               = 1'b0;
        DONE               = 1'b0;
        case (r_state)
            c_ST_ISSUE, c_ST_SETTLE: begin
                CRAM_DIAG_FUNC     = {c_FUNC_13, r_x};
                DIAG_READ_FUNC_13X = 1'b1;
                BUSY               = 1'b1;
            end
            c_ST_RELEASE: begin
                BUSY = 1'b1;
            end
            c_ST_FIN: begin
                DONE = 1'b1;
            end
            default: begin
                BUSY = 1'b0;
            end
        endcase
    end

    assign ERR      = r_err;
    assign RD_VALID = r_rd_valid;
    assign RD_FUNC  = r_rd_func;
    assign RD_DATA  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_scd_diag_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_scd_diag_reader
// Description : Bench for scd_diag_reader. An SCD responder answers each
//               issued function with per-function timing; a request-level
//               model predicts captured words, issued codes, ERR and the
//               DONE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scd_diag_reader;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst_n;
    logic        REQ;
    logic        REQ_SWEEP;
    logic [0:2]  REQ_FUNC;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic        RD_VALID;
    logic [0:2]  RD_FUNC;
    logic [0:35] RD_DATA;
    logic [0:8]  CRAM_DIAG_FUNC;
    logic        DIAG_READ_FUNC_13X;
    logic        SCDdrivingEBUS;
    logic [0:35] SCD_EBUS;

    scd_diag_reader #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .REQ                (REQ),
        .REQ_SWEEP          (REQ_SWEEP),
        .REQ_FUNC           (REQ_FUNC),
        .BUSY               (BUSY),
        .DONE               (DONE),
        .ERR                (ERR),
        .RD_VALID           (RD_VALID),
        .RD_FUNC            (RD_FUNC),
        .RD_DATA            (RD_DATA),
        .CRAM_DIAG_FUNC     (CRAM_DIAG_FUNC),
        .DIAG_READ_FUNC_13X (DIAG_READ_FUNC_13X),
        .SCDdrivingEBUS     (SCDdrivingEBUS),
        .SCD_EBUS           (SCD_EBUS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-function responder behaviour: rise delay, early drop length (0 = none), release lag
    int          cfg_d    [8];
    int          cfg_h    [8];
    int          cfg_lag  [8];
    logic [35:0] cfg_data [8];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [35:0] exp_rd   = '0;

    logic [38:0] mon_words[$];
    logic [8:0]  mon_codes[$];
    int          mon_done = 0;
    int          mon_viol = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        logic [63:0] t;
        for (int i = 0; i < 8; i++) begin
            t = {$urandom, $urandom};
            cfg_d[i] = 0; cfg_h[i] = 0; cfg_lag[i] = 0; cfg_data[i] = t[35:0];
        end
    endtask

    task automatic set_random();
        logic [63:0] t;
        for (int i = 0; i < 8; i++) begin
            t = {$urandom, $urandom};
            cfg_data[i] = t[35:0];
            cfg_d[i]   = ($urandom_range(0, 9) == 0)  ? $urandom_range(TIMEOUT - 1, TIMEOUT) : $urandom_range(0, 3);
            cfg_h[i]   = ($urandom_range(0, 11) == 0) ? $urandom_range(1, SETTLE) : 0;
            cfg_lag[i] = ($urandom_range(0, 9) == 0)  ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1) : $urandom_range(0, 2);
        end
    endtask

    // SCD responder: reacts to the issued function on falling edges
    initial begin
        int         k;
        bit         raised;
        logic [2:0] fx;
        SCDdrivingEBUS = 1'b0;
        SCD_EBUS       = '0;
        forever begin
            @(negedge clk);
            if (DIAG_READ_FUNC_13X) begin
                fx = CRAM_DIAG_FUNC[6:8];
                k = 0; raised = 1'b0;
                while (DIAG_READ_FUNC_13X && !raised) begin
                    if (k == cfg_d[fx]) begin
                        SCD_EBUS = cfg_data[fx]; SCDdrivingEBUS = 1'b1; raised = 1'b1;
                    end else begin
                        k++; @(negedge clk);
                    end
                end
                if (raised) begin
                    if (cfg_h[fx] != 0) begin
                        repeat (cfg_h[fx]) @(negedge clk);
                        SCDdrivingEBUS = 1'b0;
                        while (DIAG_READ_FUNC_13X) @(negedge clk);
                    end else begin
                        while (DIAG_READ_FUNC_13X) @(negedge clk);
                        repeat (cfg_lag[fx]) @(negedge clk);
                        SCDdrivingEBUS = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: records words, issued codes, DONE pulses and protocol violations
    initial begin
        logic prev_diag;
        prev_diag = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (RD_VALID) mon_words.push_back({RD_FUNC, RD_DATA});
            if (DONE) mon_done++;
            if (DIAG_READ_FUNC_13X && !prev_diag) begin
                mon_codes.push_back(CRAM_DIAG_FUNC);
                if (SCDdrivingEBUS) mon_viol++;
            end
            if (DIAG_READ_FUNC_13X !== (CRAM_DIAG_FUNC[0:5] == 6'o13)) mon_viol++;
            if (!DIAG_READ_FUNC_13X && (CRAM_DIAG_FUNC != 9'd0)) mon_viol++;
            if (BUSY && DONE) mon_viol++;
            prev_diag = DIAG_READ_FUNC_13X;
        end
    end

    task automatic wait_driver_low(input string tag);
        int n;
        n = 0;
        while (SCDdrivingEBUS && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check({tag, "_driver_release_timeout"}, 1, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_req(input bit sweep, input logic [2:0] func, input string tag);
        logic [38:0] exp_words[$];
        logic [8:0]  exp_codes[$];
        logic [63:0] obs;
        bit          exp_err;
        int          exp_cyc, x, cyc, bw, bc, bd, bv;
        // Request-level model from the protocol rules
        exp_err = 1'b0; exp_cyc = 0;
        x = sweep ? 0 : int'(func);
        forever begin
            exp_codes.push_back(9'o130 + 9'(x));
            if (cfg_d[x] >= TIMEOUT) begin exp_cyc += TIMEOUT + 1; exp_err = 1'b1; break; end
            exp_cyc += cfg_d[x] + 1;
            if (cfg_h[x] != 0) begin exp_cyc += cfg_h[x] + 1; exp_err = 1'b1; break; end
            exp_cyc += SETTLE;
            exp_words.push_back({3'(x), cfg_data[x]});
            exp_rd = cfg_data[x];
            if (cfg_lag[x] >= TIMEOUT) begin exp_cyc += TIMEOUT; exp_err = 1'b1; break; end
            exp_cyc += cfg_lag[x] + 1;
            if (!sweep || x == 7) break;
            x++;
        end
        bw = mon_words.size(); bc = mon_codes.size(); bd = mon_done; bv = mon_viol;
        @(negedge clk); REQ = 1'b1; REQ_SWEEP = sweep; REQ_FUNC = func;
        @(negedge clk); REQ = 1'b0; REQ_SWEEP = 1'($urandom); REQ_FUNC = 3'($urandom);
        check({tag, "_busy_after_accept"}, BUSY, 1);
        check({tag, "_err_cleared"}, ERR, 0);
        cyc = 0;
        while (!DONE && cyc < 2000) begin @(negedge clk); cyc++; end
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_busy_at_done"}, BUSY, 0);
        check({tag, "_err"}, ERR, exp_err);
        check({tag, "_rd_data"}, RD_DATA, exp_rd);
        check({tag, "_word_count"}, mon_words.size() - bw, exp_words.size());
        for (int i = 0; i < exp_words.size(); i++) begin
            obs = (bw + i < mon_words.size()) ? 64'(mon_words[bw + i]) : '1;
            check($sformatf("%s_word%0d", tag, i), obs, exp_words[i]);
        end
        check({tag, "_issue_count"}, mon_codes.size() - bc, exp_codes.size());
        for (int i = 0; i < exp_codes.size(); i++) begin
            obs = (bc + i < mon_codes.size()) ? 64'(mon_codes[bc + i]) : '1;
            check($sformatf("%s_code%0d", tag, i), obs, exp_codes[i]);
        end
        wait_driver_low(tag);
        check({tag, "_done_pulses"}, mon_done - bd, 1);
        check({tag, "_protocol"}, mon_viol - bv, 0);
        check({tag, "_err_held"}, ERR, exp_err);
    endtask

    initial begin
        int cyc, bc, bd;
        rst_n = 1'b0; REQ = 1'b0; REQ_SWEEP = 1'b0; REQ_FUNC = 3'd0;
        set_defaults();
        repeat (3) @(negedge clk);
        check("reset_outputs", {BUSY, DONE, ERR, RD_VALID, RD_FUNC, RD_DATA, CRAM_DIAG_FUNC, DIAG_READ_FUNC_13X}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_defaults(); cfg_d[3] = 1; cfg_data[3] = 36'o123456701234;
        run_req(1'b0, 3'd3, "single");

        set_defaults();
        for (int i = 0; i < 8; i++) cfg_data[i] = 36'o1000000000 + 36'(i);
        run_req(1'b1, 3'd6, "sweep");

        set_defaults(); cfg_d[5] = 1000;
        run_req(1'b0, 3'd5, "no_driver");

        set_defaults(); cfg_d[6] = TIMEOUT - 1;
        run_req(1'b0, 3'd6, "late_driver");

        set_defaults(); cfg_h[2] = 1;
        run_req(1'b1, 3'd0, "settle_drop");

        set_defaults(); cfg_lag[5] = TIMEOUT;
        run_req(1'b1, 3'd0, "stuck_release");

        set_defaults(); cfg_lag[1] = TIMEOUT - 1;
        run_req(1'b0, 3'd1, "slow_release");

        // Reset in the middle of a sweep
        set_defaults();
        @(negedge clk); REQ = 1'b1; REQ_SWEEP = 1'b1; REQ_FUNC = 3'd0;
        @(negedge clk); REQ = 1'b0;
        cyc = 0;
        while (CRAM_DIAG_FUNC !== 9'o134 && cyc < 500) begin @(negedge clk); cyc++; end
        check("midreset_reached_134", CRAM_DIAG_FUNC, 9'o134);
        #2 rst_n = 1'b0;
        #1 check("midreset_async_outputs",
                 {BUSY, DONE, ERR, RD_VALID, RD_FUNC, RD_DATA, CRAM_DIAG_FUNC, DIAG_READ_FUNC_13X}, 0);
        exp_rd = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_driver_low("midreset");
        run_req(1'b1, 3'd0, "after_reset");

        // REQ held high through a whole request
        set_defaults();
        bc = mon_codes.size(); bd = mon_done;
        @(negedge clk); REQ = 1'b1; REQ_SWEEP = 1'b0; REQ_FUNC = 3'd2;
        @(negedge clk);
        cyc = 0;
        while (!DONE && cyc < 500) begin @(negedge clk); cyc++; end
        check("held_req_one_issue", mon_codes.size() - bc, 1);
        @(negedge clk);
        check("held_req_idle_gap", {BUSY, DONE}, 2'b00);
        @(negedge clk);
        check("held_req_reaccept", BUSY, 1);
        REQ = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 500) begin @(negedge clk); cyc++; end
        check("held_req_second_done", DONE, 1);
        wait_driver_low("held_req");
        check("held_req_total_issues", mon_codes.size() - bc, 2);
        check("held_req_total_done", mon_done - bd, 2);
        exp_rd = cfg_data[2];
        check("held_req_rd_data", RD_DATA, exp_rd);

        for (int n = 0; n < 24; n++) begin
            set_random();
            run_req(1'($urandom), 3'($urandom), $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
